// File: rtl/e_x_pkg.sv
// Shared constants and types for the e^x range-reduction front end.
// Number formats: x is Q4.28, t is Q8.28, k is a signed integer, r is Q0.27.
package e_x_pkg;

    // Field widths
    localparam int X_W = 32;   // signed Q4.28 argument
    localparam int T_W = 36;   // signed Q8.28 base-2 exponent
    localparam int K_W = 5;    // signed integer part of t
    localparam int R_W = 27;   // unsigned Q0.27 residual
    localparam int C_W = 32;   // width of the two multiplier constants

    // Fractional bit counts
    localparam int X_FRAC     = 28;
    localparam int R_FRAC     = 27;
    localparam int LOG2E_FRAC = 30;
    localparam int LN2_FRAC   = 32;

    // Multiplier constants
    localparam logic [C_W-1:0] LOG2E = 32'h5C551D95;   // log2(e), Q2.30
    localparam logic [C_W-1:0] LN2   = 32'hB17217F8;   // ln(2),   Q0.32

    // Product rescaling: Q6.58 -> Q8.28 and Q0.60 -> Q0.27
    localparam int T_SHIFT = LOG2E_FRAC;
    localparam int R_SHIFT = X_FRAC + LN2_FRAC - R_FRAC;

    // Packed output word: y = {k, r}
    typedef struct packed {
        logic signed [K_W-1:0] k;
        logic        [R_W-1:0] r;
    } exp_split_t;

endpackage

// File: rtl/mul_pipe.sv
// Registered multiplier: p = (a * b) >>> SHIFT, truncated to OUT_W bits.
// Operand a is signed or unsigned depending on A_SIGNED; b is always unsigned.
// The shift is arithmetic, so dropping fraction bits rounds toward -inf.
module mul_pipe #(
    parameter int A_W      = 32,
    parameter int B_W      = 32,
    parameter bit A_SIGNED = 1'b1,
    parameter int SHIFT    = 0,
    parameter int OUT_W    = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    output logic [OUT_W-1:0] p
);

    // One spare bit so unsigned x unsigned also fits as a signed product
    localparam int P_W = A_W + B_W + 1;

    logic signed [P_W-1:0] a_ext;
    logic signed [P_W-1:0] b_ext;
    logic signed [P_W-1:0] prod;
    logic signed [P_W-1:0] shifted;
    logic                  unused_shifted;

    assign a_ext   = A_SIGNED ? {{(P_W-A_W){a[A_W-1]}}, a} : {{(P_W-A_W){1'b0}}, a};
    assign b_ext   = {{(P_W-B_W){1'b0}}, b};
    assign prod    = a_ext * b_ext;
    assign shifted = prod >>> SHIFT;

    // Bits above OUT_W are known to be sign copies for the ranges this block sees
    assign unused_shifted = ^shifted;

    // Product register
    // NOTE: the reset is in the sensitivity list, so the register clears the
    // moment rst rises instead of waiting for the next clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p <= '0;
        end else begin
            // NOTE: non-blocking, so every pipeline stage samples its
            // pre-edge input regardless of always-block ordering.
            p <= shifted[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/e_x_preprocess_core.sv
// Range reduction for e^x: e^x = 2^k * e^r with integer k and 0 <= r < ln2.
// Three register stages: x_q, t_q (inside the first multiplier), and y
// (k_q plus the residual register inside the second multiplier).
module e_x_preprocess_core
    import e_x_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] x,
    output logic [31:0] y
);

    logic [X_W-1:0]        x_q;
    logic [T_W-1:0]        t_q;
    logic signed [K_W-1:0] k_q;
    logic [R_W-1:0]        r_q;
    exp_split_t            y_s;
    logic                  unused_t_hi;

    // Stage 1: capture the argument
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
        end else begin
            x_q <= x;
        end
    end

    // Stage 2: t = floor(x * log2e) kept in Q8.28
    mul_pipe #(
        .A_W      (X_W),
        .B_W      (C_W),
        .A_SIGNED (1'b1),
        .SHIFT    (T_SHIFT),
        .OUT_W    (T_W)
    ) u_mul_log2e (
        .clk (clk),
        .rst (rst),
        .a   (x_q),
        .b   (LOG2E),
        .p   (t_q)
    );

    // Stage 3: r = frac(t) * ln2 in Q0.27; frac(t) is the low bits of the
    // two's-complement t, which is what makes negative t floor correctly
    mul_pipe #(
        .A_W      (X_FRAC),
        .B_W      (C_W),
        .A_SIGNED (1'b0),
        .SHIFT    (R_SHIFT),
        .OUT_W    (R_W)
    ) u_mul_ln2 (
        .clk (clk),
        .rst (rst),
        .a   (t_q[X_FRAC-1:0]),
        .b   (LN2),
        .p   (r_q)
    );

    // Stage 3: carry the integer part alongside the residual multiply
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q <= '0;
        end else begin
            k_q <= t_q[X_FRAC+K_W-1:X_FRAC];
        end
    end

    // |t| < 11.55, so the top bits of t only ever repeat the sign of k
    assign unused_t_hi = ^t_q[T_W-1:X_FRAC+K_W];

    assign y_s.k = k_q;
    assign y_s.r = r_q;
    assign y     = y_s;

endmodule

// File: tb/tb_e_x_preprocess_core.sv
// Self-checking bench for e_x_preprocess_core: directed points, random
// back-to-back stream against an arithmetic model, and real-valued accuracy.
module tb_e_x_preprocess_core;

    localparam int LAT = 3;
    localparam logic [31:0] R_MAX = 32'd93032639;   // largest Q0.27 value below ln2

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] x   = 32'h1000_0000;
    logic [31:0] y;

    int checks   = 0;
    int failures = 0;

    logic [31:0] stim_q[$];
    logic [31:0] spec_q[$];
    int          tol_q[$];

    e_x_preprocess_core dut (
        .clk (clk),
        .rst (rst),
        .x   (x),
        .y   (y)
    );

    always #5 clk = ~clk;

    // Compare got against want as signed 32-bit values with an absolute tolerance
    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want, input int tol = 0);
        longint d;
        d = longint'($signed(got)) - longint'($signed(want));
        if (d < 0) d = -d;
        checks++;
        if (d > longint'(tol)) begin
            failures++;
            $display("FAIL %s: got %h want %h (tol %0d)", tag, got, want, tol);
        end
    endtask

    // Reference: k = floor(x*log2e), r = (x*log2e - k)*ln2, using the fixed constants
    function automatic logic [31:0] model_y(input logic [31:0] xin);
        longint xs, t, k, u, r;
        xs = longint'($signed(xin));
        t  = (xs * 64'sh5C551D95) >>> 30;        // x*log2e in units of 2^-28, floored
        k  = t >>> 28;                           // integer floor
        u  = t - (k <<< 28);                     // fractional part, 0 <= u < 2^28
        r  = (u * 64'sh00000000B17217F8) >>> 33; // scale by ln2, keep 27 frac bits
        return {k[4:0], r[26:0]};
    endfunction

    // Full set of checks for one output word produced from xin
    task automatic check_output(input logic [31:0] xin, input int idx);
        int  kk;
        real xr, ratio, err;
        check("model", y, model_y(xin));
        if (tol_q[idx] >= 0) check("spec_point", y, spec_q[idx], tol_q[idx]);
        kk = $signed(y[31:27]);
        check("k_range", 32'(int'(kk >= -12 && kk <= 11)), 32'd1);
        check("r_range", 32'(int'(y[26:0] <= R_MAX)), 32'd1);
        xr    = real'($signed(xin)) / 268435456.0;
        ratio = $pow(2.0, real'(kk)) * $exp(real'(y[26:0]) / 134217728.0) / $exp(xr);
        err   = ratio - 1.0;
        if (err < 0.0) err = -err;
        check("relerr_2m27", 32'($rtoi(err * 134217728.0)), 32'd0, 7);
    endtask

    // Drive stim_q one value per cycle and check each y LAT cycles later
    task automatic run_stream();
        int n;
        n = stim_q.size();
        for (int i = 0; i < n + LAT; i++) begin
            @(negedge clk);
            if (i >= LAT) check_output(stim_q[i-LAT], i - LAT);
            if (i < n) x = stim_q[i];
            else       x = $urandom;
        end
    endtask

    task automatic add(input logic [31:0] xv, input logic [31:0] sv, input int tv);
        stim_q.push_back(xv);
        spec_q.push_back(sv);
        tol_q.push_back(tv);
    endtask

    initial begin
        // Fill the pipeline, then reset mid-cycle: outputs must clear at once
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1 check("rst_async", y, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_hold", y, 32'h0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_e1", y, 32'h0);
        @(negedge clk);
        check("post_rst_e2", y, 32'h0);
        @(negedge clk);
        check("post_rst_first", y, 32'h0A74_6F40, 4);

        // Directed points, back to back
        add(32'h0000_0000, 32'h0000_0000, 0);
        add(32'h0800_0000, 32'h0400_0000, 4);
        add(32'hFFFF_FFFF, 32'hFD8B_90BE, 4);
        add(32'h0000_0001, 32'h0000_0000, 1);
        add(32'h1000_0000, 32'h0A74_6F40, 4);
        add(32'h8000_0000, 32'h0, -1);
        add(32'h7FFF_FFFF, 32'h0, -1);
        add(32'h0000_0000, 32'h0000_0000, 0);
        add(32'hF000_0000, 32'h0, -1);
        run_stream();

        // Random sweep over the full [-8, 8) range
        stim_q.delete(); spec_q.delete(); tol_q.delete();
        for (int i = 0; i < 300; i++) add($urandom, 32'h0, -1);
        run_stream();

        // Mid-stream reset: nothing in flight may survive
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            x = $urandom | 32'h0100_0000;
        end
        #2 rst = 1'b1;
        #1 check("flush_async", y, 32'h0);
        @(negedge clk);
        x   = 32'h0;
        rst = 1'b0;
        for (int i = 0; i < LAT + 1; i++) begin
            @(negedge clk);
            check("flush_zero", y, 32'h0);
        end

        // Recovery after the flush
        stim_q.delete(); spec_q.delete(); tol_q.delete();
        add(32'h1000_0000, 32'h0A74_6F40, 4);
        add(32'hFFFF_FFFF, 32'hFD8B_90BE, 4);
        for (int i = 0; i < 20; i++) add($urandom, 32'h0, -1);
        run_stream();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
